// File: rtl/cnn_frame_writer_pkg.sv
// ============================================================================
// Module      : cnn_frame_writer_pkg
// Description : Shared state encoding and lane/pixel-width defaults for the
//               CNN output frame writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_frame_writer_pkg;

    // Defaults for stored pixel width and pixels packed per buffer word
    localparam int C_W_PIX_DEF = 8;
    localparam int C_PACK_DEF  = 4;

    // Writer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cnn_pix_quant.sv
// ============================================================================
// Module      : cnn_pix_quant
// Description : Combinational reduction of a signed W_IN-bit pixel to an
//               unsigned W_PIX-bit stored pixel.
//               Build option CNN_WRITER_CLAMP_EN: saturate to [0, 2^W_PIX-1]
//               (ReLU + clamp). Without it the low W_PIX bits are kept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_pix_quant #(
    parameter int W_IN  = 16,
    parameter int W_PIX = 8
) (
    input  logic [W_IN-1:0]  i_data,
    output logic [W_PIX-1:0] o_pix
);

`ifdef CNN_WRITER_CLAMP_EN
    // Negative values floor at zero; anything above the stored range saturates
    always_comb begin
        if (i_data[W_IN-1]) begin
            o_pix = '0;
        end else if (|i_data[W_IN-2:W_PIX]) begin
            o_pix = '1;
        end else begin
            o_pix = i_data[W_PIX-1:0];
        end
    end
`else
    // Upper bits are intentionally discarded by plain truncation
    logic w_unused_msbs;
    assign w_unused_msbs = ^i_data[W_IN-1:W_PIX];
    assign o_pix         = i_data[W_PIX-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/cnn_frame_writer.sv
// ============================================================================
// Module      : cnn_frame_writer
// Description : Accepts the processed pixel stream, quantises each pixel,
//               packs PACK pixels per word and writes words sequentially into
//               the output frame buffer from q_base_addr. Tracks row/col of
//               the next expected pixel and pulses o_done at frame end.
//               Build option CNN_WRITER_CLAMP_EN selects saturating
//               quantisation (see cnn_pix_quant).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_frame_writer
    import cnn_frame_writer_pkg::*;
#(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 25,
    parameter int W_IN         = 16,
    parameter int W_PIX        = C_W_PIX_DEF,
    parameter int PACK         = C_PACK_DEF,   // power of 2, >= 2
    parameter int W_ADDR       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_FRAME_SIZE-1:0] q_frame_size,
    input  logic [W_ADDR-1:0]       q_base_addr,
    input  logic                    q_start,
    input  logic                    i_valid,
    input  logic [W_IN-1:0]         i_data,
    output logic                    o_wr_en,
    output logic [W_ADDR-1:0]       o_wr_addr,
    output logic [W_PIX*PACK-1:0]   o_wr_data,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err_ovf
);

    localparam int LANE_W = $clog2(PACK);

    state_t                  r_state;
    logic [W_FRAME_SIZE-1:0] r_pix_cnt;
    logic [W_ADDR-1:0]       r_word_idx;
    logic [W_PIX*PACK-1:0]   r_lanes;

    logic [W_PIX*PACK-1:0]   w_next_lanes;
    logic [W_PIX-1:0]        w_pix_q;
    logic [LANE_W-1:0]       w_lane;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_word_end;

    cnn_pix_quant #(
        .W_IN  (W_IN),
        .W_PIX (W_PIX)
    ) u_quant (
        .i_data (i_data),
        .o_pix  (w_pix_q)
    );

    // Lane is the pixel index mod PACK; a word closes on its last lane or on
    // the final pixel of the frame (leaving the remaining lanes zero).
    assign w_accept   = (r_state == ST_RUN) && i_valid;
    assign w_lane     = r_pix_cnt[LANE_W-1:0];
    assign w_last     = (r_pix_cnt == (q_frame_size - W_FRAME_SIZE'(1)));
    assign w_word_end = (w_lane == LANE_W'(PACK - 1)) || w_last;

    // Current word with the incoming quantised pixel dropped into its lane
    always_comb begin
        w_next_lanes = r_lanes;
        w_next_lanes[w_lane*W_PIX +: W_PIX] = w_pix_q;
    end

    // Sequencer, counters, packer and write register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pix_cnt  <= '0;
            r_word_idx <= '0;
            r_lanes    <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_row      <= '0;
            o_col      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err_ovf  <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (q_start) begin
                        o_err_ovf  <= 1'b0;
                        r_pix_cnt  <= '0;
                        r_word_idx <= '0;
                        r_lanes    <= '0;
                        o_row      <= '0;
                        o_col      <= '0;
                        if (q_frame_size == '0) begin
                            r_state <= ST_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            o_busy  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        r_pix_cnt <= r_pix_cnt + W_FRAME_SIZE'(1);

                        if (w_word_end) begin
                            o_wr_en    <= 1'b1;
                            o_wr_addr  <= q_base_addr + r_word_idx;
                            o_wr_data  <= w_next_lanes;
                            r_lanes    <= '0;
                            r_word_idx <= r_word_idx + W_ADDR'(1);
                        end else begin
                            r_lanes <= w_next_lanes;
                        end

                        if (w_last) begin
                            o_row   <= '0;
                            o_col   <= '0;
                            r_state <= ST_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else if (o_col == (q_width - W_SIZE'(1))) begin
                            o_col <= '0;
                            o_row <= o_row + W_SIZE'(1);
                        end else begin
                            o_col <= o_col + W_SIZE'(1);
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Pixels arriving while not running are dropped and flagged
            if (i_valid && (r_state != ST_RUN)) begin
                o_err_ovf <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cnn_frame_writer.sv
// ============================================================================
// Module      : tb_cnn_frame_writer
// Description : Self-checking bench for cnn_frame_writer. Expected buffer
//               writes are queued when a frame is issued and compared by an
//               independent monitor. Honours CNN_WRITER_CLAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_frame_writer;

    localparam int W_SIZE       = 12;
    localparam int W_FRAME_SIZE = 25;
    localparam int W_IN         = 16;
    localparam int W_PIX        = 8;
    localparam int PACK         = 4;
    localparam int W_ADDR       = 16;

    logic                    clk;
    logic                    rst;
    logic [W_SIZE-1:0]       q_width;
    logic [W_FRAME_SIZE-1:0] q_frame_size;
    logic [W_ADDR-1:0]       q_base_addr;
    logic                    q_start;
    logic                    i_valid;
    logic [W_IN-1:0]         i_data;
    logic                    o_wr_en;
    logic [W_ADDR-1:0]       o_wr_addr;
    logic [W_PIX*PACK-1:0]   o_wr_data;
    logic [W_SIZE-1:0]       o_row;
    logic [W_SIZE-1:0]       o_col;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_err_ovf;

    cnn_frame_writer #(
        .W_SIZE       (W_SIZE),
        .W_FRAME_SIZE (W_FRAME_SIZE),
        .W_IN         (W_IN),
        .W_PIX        (W_PIX),
        .PACK         (PACK),
        .W_ADDR       (W_ADDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .q_width      (q_width),
        .q_frame_size (q_frame_size),
        .q_base_addr  (q_base_addr),
        .q_start      (q_start),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_row        (o_row),
        .o_col        (o_col),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err_ovf    (o_err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  pix[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  done_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference quantiser written from the stored-pixel rules
    function automatic int quant(input int v);
`ifdef CNN_WRITER_CLAMP_EN
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
`else
        return v & 255;
`endif
    endfunction

    // Expected word list for the frame held in pix[]
    task automatic push_expected(input int base, input int n);
        int words;
        logic [31:0] d;
        words = (n + PACK - 1) / PACK;
        for (int k = 0; k < words; k++) begin
            d = '0;
            for (int j = 0; j < PACK; j++) begin
                if (k * PACK + j < n)
                    d = d | (32'(quant(pix[k*PACK+j])) << (8 * j));
            end
            exp_q.push_back('{addr: 16'(base + k), data: d, last: (k == words - 1)});
        end
    endtask

    // Monitor: every write must match the oldest expected write
    always @(negedge clk) begin
        if (o_done) done_cnt++;
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", longint'(o_wr_addr), longint'(mon_e.addr));
                check("wr_data", longint'(o_wr_data), longint'(mon_e.data));
                check("done_with_write", longint'(o_done), longint'(mon_e.last));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},   o_wr_en,   0);
        check({tag, "_wr_addr"}, o_wr_addr, 0);
        check({tag, "_wr_data"}, o_wr_data, 0);
        check({tag, "_row"},     o_row,     0);
        check({tag, "_col"},     o_col,     0);
        check({tag, "_busy"},    o_busy,    0);
        check({tag, "_done"},    o_done,    0);
        check({tag, "_err_ovf"}, o_err_ovf, 0);
    endtask

    // Issue one frame from pix[] with random gaps in [gmin, gmax]
    task automatic run_frame(input int w, input int n, input int base,
                             input int gmin, input int gmax);
        int dc0;
        push_expected(base, n);
        q_width      = W_SIZE'(w);
        q_frame_size = W_FRAME_SIZE'(n);
        q_base_addr  = W_ADDR'(base);
        q_start      = 1'b1;
        dc0          = done_cnt;
        tick;
        q_start = 1'b0;
        if (n > 0) check("busy_in_run", o_busy, 1);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gmax, gmin)) begin
                i_valid = 1'b0;
                tick;
            end
            i_valid = 1'b1;
            i_data  = 16'(pix[k]);
            tick;
            i_valid = 1'b0;
            if (k + 1 == n) begin
                check("row_end", o_row, 0);
                check("col_end", o_col, 0);
                check("busy_after_last", o_busy, 0);
            end else begin
                check("row", o_row, (k + 1) / w);
                check("col", o_col, (k + 1) % w);
            end
        end
        tick;
        tick;
        check("done_pulses", done_cnt - dc0, 1);
        check("pending_writes", exp_q.size(), 0);
        check("err_ovf_clear", o_err_ovf, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int dc0;
        rst          = 1'b1;
        q_width      = '0;
        q_frame_size = '0;
        q_base_addr  = '0;
        q_start      = 1'b0;
        i_valid      = 1'b0;
        i_data       = '0;
        repeat (3) tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;

        // Back-to-back full frame of two words
        pix = {1, 2, 3, 4, 5, 6, 7, 8};
        run_frame(4, 8, 'h100, 0, 0);

        // Partial final word with single-cycle gaps
        pix = {1, 2, 3, 4, 5, 6};
        run_frame(4, 6, 'h200, 1, 1);

        // Quantisation corner values
        pix = {-5, 300, 255, 0};
        run_frame(4, 4, 'h300, 0, 0);

        // Row/col walk on a 3-wide frame
        pix = {10, 20, 30, 40, 50, 60};
        run_frame(3, 6, 'h400, 0, 1);

        // Reset in the middle of a frame drops the partial word
        q_width      = 12'd4;
        q_frame_size = 25'd8;
        q_base_addr  = 16'h0450;
        q_start      = 1'b1;
        tick;
        q_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = 16'(k + 1);
            tick;
        end
        i_valid = 1'b0;
        rst     = 1'b1;
        tick;
        tick;
        check_all_zero("midreset");
        rst = 1'b0;
        tick;
        pix = {11, 12, 13, 14, 15, 16, 17, 18};
        run_frame(4, 8, 'h500, 0, 0);

        // Pixel in idle raises the sticky error without writing
        i_valid = 1'b1;
        i_data  = 16'h0007;
        tick;
        i_valid = 1'b0;
        tick;
        tick;
        check("err_ovf_set", o_err_ovf, 1);
        check("no_write_on_ovf", exp_q.size(), 0);

        // Zero-size frame: start clears the error and completes at once
        q_frame_size = '0;
        q_start      = 1'b1;
        dc0          = done_cnt;
        tick;
        q_start = 1'b0;
        check("err_ovf_cleared", o_err_ovf, 0);
        check("zero_frame_done", o_done, 1);
        check("zero_frame_busy", o_busy, 0);
        tick;
        check("zero_frame_done_drop", o_done, 0);
        tick;
        check("zero_frame_pulses", done_cnt - dc0, 1);

        // Randomised frames, including base addresses that wrap
        for (int f = 0; f < 25; f++) begin
            int w, n, base;
            w    = $urandom_range(7, 1);
            n    = $urandom_range(20, 1);
            base = ($urandom_range(3, 0) == 0) ? 'hFFFE : $urandom_range(16'hFFFF, 0);
            pix.delete();
            for (int k = 0; k < n; k++) pix.push_back(int'($urandom_range(65535, 0)) - 32768);
            run_frame(w, n, base, 0, 2);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
